dsm2_dac: RTL and testbench

- Second-order delta-sigma modulator that turns a signed PCM sample stream into a 1-bit pulse-density output.
- One instance per audio channel. Input comes from the sound mixer at system clock rate; the output drives a pin through an external RC low-pass.
- Ones density tracks (dac_i + 2^(nbits-1)) / 2^nbits.

---
 rtl/dsm_pkg.sv | 21 ++
 rtl/dsm_sat_integrator.sv | 43 ++++
 rtl/dsm2_dac.sv | 61 ++++++
 tb/tb_dsm2_dac.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/dsm_pkg.sv
// rtl/dsm_pkg.sv - shared widths, saturation limits and feedback magnitude for the delta-sigma DAC
package dsm_pkg;

  function automatic int dsm_width(input int nbits);
    return nbits + 4;
  endfunction

  // Integrators clamp to the full signed range of a W-bit register.
  function automatic longint sat_max(input int w);
    return (longint'(1) << (w - 1)) - 1;
  endfunction

  function automatic longint sat_min(input int w);
    return -(longint'(1) << (w - 1));
  endfunction

  function automatic longint fb_mag(input int nbits);
    return longint'(1) << (nbits - 1);
  endfunction

endpackage

// File: rtl/dsm_sat_integrator.sv
// rtl/dsm_sat_integrator.sv - W-bit accumulator that clamps instead of wrapping
module dsm_sat_integrator
  import dsm_pkg::*;
#(
  parameter int W = 20
) (
  input  logic                clock_i,
  input  logic                reset_i,
  input  logic signed [W+1:0] addend_i,
  output logic signed [W-1:0] acc_o,
  output logic signed [W-1:0] next_o
);

  localparam logic signed [W+1:0] LIM_HI = (W+2)'(sat_max(W));
  localparam logic signed [W+1:0] LIM_LO = (W+2)'(sat_min(W));

  logic signed [W-1:0] r_acc;
  logic signed [W+1:0] w_sum;
  logic signed [W-1:0] w_next;

  assign w_sum = {{2{r_acc[W-1]}}, r_acc} + addend_i;

  always_comb begin
    w_next = w_sum[W-1:0];
    if (w_sum > LIM_HI) begin
      w_next = LIM_HI[W-1:0];
    end else if (w_sum < LIM_LO) begin
      w_next = LIM_LO[W-1:0];
    end
  end

  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      r_acc <= '0;
    end else begin
      r_acc <= w_next;
    end
  end

  assign acc_o  = r_acc;
  assign next_o = w_next;

endmodule

// File: rtl/dsm2_dac.sv
// rtl/dsm2_dac.sv - second-order delta-sigma modulator, signed PCM in, 1-bit pulse density out
module dsm2_dac
  import dsm_pkg::*;
#(
  parameter int nbits = 16
) (
  input  logic                    clock_i,
  input  logic                    reset_i,
  input  logic signed [nbits-1:0] dac_i,
  output logic                    dac_o
);

  localparam int W = dsm_width(nbits);
  localparam logic signed [W+1:0] FB_POS = (W+2)'(fb_mag(nbits));
  localparam logic signed [W+1:0] FB_NEG = -FB_POS;

  logic                r_out;
  logic signed [W+1:0] w_x;
  logic signed [W+1:0] w_fb;
  logic signed [W+1:0] w_int1_ext;
  logic signed [W+1:0] w_add1;
  logic signed [W+1:0] w_add2;
  logic signed [W-1:0] w_int1;
  logic signed [W-1:0] w_int2_next;
  logic signed [W-1:0] w_int1_next_unused;
  logic signed [W-1:0] w_int2_acc_unused;

  assign w_x        = {{(W+2-nbits){dac_i[nbits-1]}}, dac_i};
  assign w_fb       = r_out ? FB_POS : FB_NEG;
  assign w_int1_ext = {{2{w_int1[W-1]}}, w_int1};
  assign w_add1     = w_x - w_fb;
  // Second stage integrates the registered int1, not this cycle's s1.
  assign w_add2     = w_int1_ext - w_fb;

  dsm_sat_integrator #(.W(W)) u_int1 (
    .clock_i  (clock_i),
    .reset_i  (reset_i),
    .addend_i (w_add1),
    .acc_o    (w_int1),
    .next_o   (w_int1_next_unused)
  );

  dsm_sat_integrator #(.W(W)) u_int2 (
    .clock_i  (clock_i),
    .reset_i  (reset_i),
    .addend_i (w_add2),
    .acc_o    (w_int2_acc_unused),
    .next_o   (w_int2_next)
  );

  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      r_out <= 1'b0;
    end else begin
      r_out <= ~w_int2_next[W-1];
    end
  end

  assign dac_o = r_out;

endmodule

// File: tb/tb_dsm2_dac.sv
// tb/tb_dsm2_dac.sv - randomized and directed checks of dsm2_dac against an arithmetic model
`timescale 1ns/1ps
module tb_dsm2_dac;

  localparam int     NB   = 16;
  localparam int     WW   = NB + 4;
  localparam longint FB   = 64'sd32768;
  localparam longint SMAX = (64'sd1 <<< (WW - 1)) - 1;
  localparam longint SMIN = -(64'sd1 <<< (WW - 1));

  logic                 clk = 1'b0;
  logic                 reset_i = 1'b0;
  logic signed [NB-1:0] dac_i = '0;
  logic                 dac_o;

  int n_cmp = 0;
  int n_bad = 0;
  int n_print = 0;
  int ones = 0;
  bit cmp_en = 1'b1;

  longint m_i1 = 0;
  longint m_i2 = 0;
  bit     m_out = 1'b0;

  dsm2_dac #(.nbits(NB)) dut (
    .clock_i (clk),
    .reset_i (reset_i),
    .dac_i   (dac_i),
    .dac_o   (dac_o)
  );

  always #5 clk = ~clk;

  function automatic longint clamp(input longint v);
    if (v > SMAX) return SMAX;
    if (v < SMIN) return SMIN;
    return v;
  endfunction

  function automatic void mstep(inout longint i1, inout longint i2, inout bit o, input longint x);
    longint fb, s1, s2;
    fb = o ? FB : -FB;
    s1 = i1 + x - fb;
    s2 = i2 + i1 - fb;
    i1 = clamp(s1);
    i2 = clamp(s2);
    o  = (i2 >= 0);
  endfunction

  task automatic check(input string name, input longint act, input longint lo, input longint hi);
    n_cmp++;
    if (act < lo || act > hi) begin
      n_bad++;
      $display("FAIL %s: got %0d, required %0d..%0d", name, act, lo, hi);
    end
  endtask

  task automatic tick(input int v);
    dac_i = NB'(v);
    @(posedge clk);
    if (reset_i) mstep(m_i1, m_i2, m_out, longint'(v));
    else begin m_i1 = 0; m_i2 = 0; m_out = 1'b0; end
    #1;
    ones += int'(dac_o);
  endtask

  // Bit-exact comparison against the model on every cycle.
  always @(negedge clk) begin
    if (cmp_en) begin
      n_cmp++;
      if (dac_o !== m_out) begin
        n_bad++;
        if (n_print < 20) begin
          n_print++;
          $display("FAIL bitexact t=%0t dac_o=%0b model=%0b", $time, dac_o, m_out);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    bit     first4 [4];
    bit     ref_seq [64];
    longint r1, r2, sum;
    bit     ro;
    int     v;
    real    dens, want;

    // Reset held with a nonzero input.
    for (int i = 0; i < 10; i++) begin
      tick(16'sh1234);
      check("reset_hold", dac_o, 0, 0);
    end
    reset_i = 1'b1;

    // Zero input from zero state.
    ones = 0;
    for (int i = 0; i < 4; i++) begin
      tick(0);
      first4[i] = dac_o;
    end
    check("zero_first0", first4[0], 1, 1);
    check("zero_first1", first4[1], 1, 1);
    check("zero_first2", first4[2], 1, 1);
    check("zero_first3", first4[3], 0, 0);
    for (int i = 4; i < 4096; i++) tick(0);
    check("zero_density", ones, 2046, 2050);

    // Half scale in both directions.
    repeat (256) tick(16384);
    ones = 0;
    repeat (4096) tick(16384);
    check("half_pos_density", ones, 3064, 3080);
    repeat (256) tick(-16384);
    ones = 0;
    repeat (4096) tick(-16384);
    check("half_neg_density", ones, 1016, 1032);

    // Full scale, then recovery to zero input.
    ones = 0;
    repeat (2000) tick(32767);
    check("full_scale_density", ones, 1940, 2000);
    check("model_int1_in_range", m_i1, SMIN, SMAX);
    check("model_int2_in_range", m_i2, SMIN, SMAX);
    repeat (64) tick(0);
    ones = 0;
    repeat (256) tick(0);
    check("recovery_density", ones, 123, 133);

    // Reset pulse mid-stream; output must restart like a fresh run.
    r1 = 0; r2 = 0; ro = 1'b0;
    for (int i = 0; i < 64; i++) begin
      mstep(r1, r2, ro, -64'sd16384);
      ref_seq[i] = ro;
    end
    repeat (100) tick(-16384);
    for (int i = 0; i < 16 && !m_out; i++) tick(-16384);
    check("pre_reset_out_high", dac_o, 1, 1);
    reset_i = 1'b0;
    m_i1 = 0; m_i2 = 0; m_out = 1'b0;
    #1;
    check("async_assert", dac_o, 0, 0);
    tick(-16384);
    check("reset_low_out", dac_o, 0, 0);
    reset_i = 1'b1;
    for (int i = 0; i < 64; i++) begin
      tick(-16384);
      check($sformatf("fresh_run_%0d", i), dac_o, ref_seq[i], ref_seq[i]);
    end

    // Random steps within +/-8000.
    ones = 0;
    sum = 0;
    for (int i = 0; i < 8192; i++) begin
      v = int'($urandom_range(0, 16000)) - 8000;
      sum += v;
      tick(v);
    end
    dens = real'(ones) / 8192.0;
    want = (real'(sum) / 8192.0) / 65536.0 + 0.5;
    check("random_density_x10000", longint'((dens - want) * 10000.0), -100, 100);

    cmp_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
